// File: rtl/stereo_pkg.sv
// stereo_pkg: shared frame geometry defaults and scheduler state encoding
package stereo_pkg;
  localparam int DEF_ROWS = 320;
  localparam int DEF_WORDS_PER_ROW = 40;
  localparam int DEF_BLOCK_SIZE = 6;
  localparam int DEF_MAX_DISP = 4;
  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_FETCH, COMPUTE, WAIT_COST, NEXT_DISP, REPORT, NEXT_BLOCK
  } state_t;
endpackage

// File: rtl/block_match_scheduler_if.sv
// block_match_scheduler_if: frame control, fetch, cost and result handshakes
interface block_match_scheduler_if import stereo_pkg::*; #(
  parameter int ROWS = DEF_ROWS,
  parameter int WORDS_PER_ROW = DEF_WORDS_PER_ROW,
  parameter int MAX_DISP = DEF_MAX_DISP
);
  localparam int YW = $clog2(ROWS) + 1;
  localparam int XW = $clog2(WORDS_PER_ROW) + 1;
  localparam int DW = $clog2(MAX_DISP) + 1;
  logic start_in;
  logic busy_out;
  logic done_out;
  logic fetch_valid_out;
  logic [YW-1:0] left_current_y;
  logic [YW-1:0] right_current_y;
  logic [XW-1:0] left_word_idx;
  logic [XW-1:0] right_word_idx;
  logic fetch_done_in;
  logic compute_valid_out;
  logic cost_valid_in;
  logic [15:0] cost_in;
  logic result_valid_out;
  logic [YW-1:0] result_y_out;
  logic [XW-1:0] result_x_out;
  logic [DW-1:0] result_disp_out;
  logic [15:0] result_cost_out;
  modport master (
    input start_in, fetch_done_in, cost_valid_in, cost_in,
    output busy_out, done_out, fetch_valid_out, left_current_y, right_current_y,
    left_word_idx, right_word_idx, compute_valid_out, result_valid_out,
    result_y_out, result_x_out, result_disp_out, result_cost_out
  );
  modport slave (
    output start_in, fetch_done_in, cost_valid_in, cost_in,
    input busy_out, done_out, fetch_valid_out, left_current_y, right_current_y,
    left_word_idx, right_word_idx, compute_valid_out, result_valid_out,
    result_y_out, result_x_out, result_disp_out, result_cost_out
  );
endinterface

// File: rtl/min_cost_tracker.sv
// min_cost_tracker: running minimum cost and its disparity, ties keep the earlier one
module min_cost_tracker #(
  parameter int DW = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  input  logic [15:0] cost,
  input  logic [DW-1:0] disp,
  output logic [15:0] best_cost,
  output logic [DW-1:0] best_disp
);
  // strict compare so an equal cost never displaces the lower disparity
  always_ff @(posedge clk)
    if (rst || clear) begin
      best_cost <= 16'hFFFF;
      best_disp <= '0;
    end else if (load && cost < best_cost) begin
      best_cost <= cost;
      best_disp <= disp;
    end
endmodule

// File: rtl/block_match_scheduler.sv
// block_match_scheduler: walks blocks and disparities of a frame, reports best match per block
module block_match_scheduler import stereo_pkg::*; #(
  parameter int ROWS = DEF_ROWS,
  parameter int WORDS_PER_ROW = DEF_WORDS_PER_ROW,
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int MAX_DISP = DEF_MAX_DISP
) (
  input logic clk_in,
  input logic rst_in,
  block_match_scheduler_if.master bus
);
  localparam int YW = $clog2(ROWS) + 1;
  localparam int XW = $clog2(WORDS_PER_ROW) + 1;
  localparam int DW = $clog2(MAX_DISP) + 1;
  state_t state;
  logic [YW-1:0] y;
  logic [XW-1:0] x, rx;
  logic [DW-1:0] d, best_disp;
  logic [15:0] best_cost;
  logic [31:0] d_n, x_n, y_n;
  logic clear, load;
  // next-step candidates in 32 bits so boundary compares cannot wrap
  always_comb begin
    d_n = 32'(d) + 32'd1;
    x_n = 32'(x) + 32'd1;
    y_n = 32'(y) + 32'(2 * BLOCK_SIZE);
  end
  assign clear = (state == IDLE && bus.start_in) || state == NEXT_BLOCK;
  assign load = state == WAIT_COST && bus.cost_valid_in;
  assign bus.left_current_y = y;
  assign bus.right_current_y = y;
  assign bus.left_word_idx = x;
  assign bus.right_word_idx = rx;
  min_cost_tracker #(.DW(DW)) u_tracker (
    .clk(clk_in), .rst(rst_in), .clear(clear), .load(load),
    .cost(bus.cost_in), .disp(d), .best_cost(best_cost), .best_disp(best_disp)
  );
  // frame walk; pulses are set on entry so they coincide with their state
  always_ff @(posedge clk_in)
    if (rst_in) begin
      state <= IDLE;
      y <= '0;
      x <= '0;
      rx <= '0;
      d <= '0;
      bus.busy_out <= 1'b0;
      bus.done_out <= 1'b0;
      bus.fetch_valid_out <= 1'b0;
      bus.compute_valid_out <= 1'b0;
      bus.result_valid_out <= 1'b0;
      bus.result_y_out <= '0;
      bus.result_x_out <= '0;
      bus.result_disp_out <= '0;
      bus.result_cost_out <= '0;
    end else begin
      bus.done_out <= 1'b0;
      bus.fetch_valid_out <= 1'b0;
      bus.compute_valid_out <= 1'b0;
      bus.result_valid_out <= 1'b0;
      case (state)
        IDLE:
          if (bus.start_in) begin
            state <= FETCH;
            y <= '0;
            x <= '0;
            rx <= '0;
            d <= '0;
            bus.busy_out <= 1'b1;
            bus.fetch_valid_out <= 1'b1;
          end
        FETCH: state <= WAIT_FETCH;
        WAIT_FETCH:
          if (bus.fetch_done_in) begin
            state <= COMPUTE;
            bus.compute_valid_out <= 1'b1;
          end
        COMPUTE: state <= WAIT_COST;
        WAIT_COST: if (bus.cost_valid_in) state <= NEXT_DISP;
        NEXT_DISP:
          if (d_n < 32'(MAX_DISP) && d_n <= 32'(x)) begin
            state <= FETCH;
            d <= DW'(d_n);
            rx <= rx - XW'(1);
            bus.fetch_valid_out <= 1'b1;
          end else begin
            state <= REPORT;
            bus.result_valid_out <= 1'b1;
            bus.result_y_out <= y;
            bus.result_x_out <= x;
            bus.result_disp_out <= best_disp;
            bus.result_cost_out <= best_cost;
          end
        REPORT: state <= NEXT_BLOCK;
        NEXT_BLOCK: begin
          d <= '0;
          if (x_n <= 32'(WORDS_PER_ROW - 2)) begin
            state <= FETCH;
            x <= XW'(x_n);
            rx <= XW'(x_n);
            bus.fetch_valid_out <= 1'b1;
          end else if (y_n <= 32'(ROWS)) begin
            state <= FETCH;
            x <= '0;
            rx <= '0;
            y <= YW'(32'(y) + 32'(BLOCK_SIZE));
            bus.fetch_valid_out <= 1'b1;
          end else begin
            state <= IDLE;
            bus.done_out <= 1'b1;
            bus.busy_out <= 1'b0;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_block_match_scheduler.sv
// tb_block_match_scheduler: directed and randomized checks against a frame-level reference model
module tb_block_match_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  block_match_scheduler_if #(.ROWS(6), .WORDS_PER_ROW(3), .MAX_DISP(4)) bus_a();
  block_match_scheduler_if bus_b();
  block_match_scheduler #(.ROWS(6), .WORDS_PER_ROW(3), .BLOCK_SIZE(6), .MAX_DISP(4)) dut_a (
    .clk_in(clk), .rst_in(rst), .bus(bus_a.master)
  );
  block_match_scheduler dut_b (.clk_in(clk), .rst_in(rst), .bus(bus_b.master));
  int checks = 0;
  int errors = 0;
  typedef struct {int y; int x; int d; int c;} ent_t;
  ent_t fq[$];
  ent_t rq[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic serve_a(input int ex, input int erx, input int c);
    int n = 0;
    while (!bus_a.fetch_valid_out && n < 50) begin tick(); n++; end
    chk("a_fetch_wait", 32'(n < 50), 1);
    chk("a_fetch_y", bus_a.left_current_y, 0);
    chk("a_fetch_x", bus_a.left_word_idx, ex);
    chk("a_fetch_rx", bus_a.right_word_idx, erx);
    tick();
    bus_a.fetch_done_in = 1'b1;
    tick();
    bus_a.fetch_done_in = 1'b0;
    chk("a_compute", bus_a.compute_valid_out, 1);
    tick();
    bus_a.cost_valid_in = 1'b1;
    bus_a.cost_in = 16'(c);
    tick();
    bus_a.cost_valid_in = 1'b0;
  endtask
  task automatic wait_res_a(input int ex, input int ed, input int ec);
    int n = 0;
    while (!bus_a.result_valid_out && n < 50) begin tick(); n++; end
    chk("a_res_wait", 32'(n < 50), 1);
    chk("a_res_y", bus_a.result_y_out, 0);
    chk("a_res_x", bus_a.result_x_out, ex);
    chk("a_res_disp", bus_a.result_disp_out, ed);
    chk("a_res_cost", bus_a.result_cost_out, ec);
  endtask
  task automatic frame_a(input int c0, input int c1, input int c2);
    int n = 0;
    bus_a.start_in = 1'b1;
    tick();
    bus_a.start_in = 1'b0;
    chk("a_busy", bus_a.busy_out, 1);
    serve_a(0, 0, c0);
    wait_res_a(0, 0, c0);
    serve_a(1, 1, c1);
    serve_a(1, 0, c2);
    wait_res_a(1, c2 < c1 ? 1 : 0, c2 < c1 ? c2 : c1);
    while (!bus_a.done_out && n < 50) begin tick(); n++; end
    chk("a_done_wait", 32'(n < 50), 1);
    chk("a_done_busy", bus_a.busy_out, 0);
  endtask
  task automatic chk_idle_b(input string tag);
    chk({tag, "_fv"}, bus_b.fetch_valid_out, 0);
    chk({tag, "_cv"}, bus_b.compute_valid_out, 0);
    chk({tag, "_rv"}, bus_b.result_valid_out, 0);
    chk({tag, "_busy"}, bus_b.busy_out, 0);
    chk({tag, "_done"}, bus_b.done_out, 0);
    chk({tag, "_ly"}, bus_b.left_current_y, 0);
    chk({tag, "_ry"}, bus_b.right_current_y, 0);
    chk({tag, "_lx"}, bus_b.left_word_idx, 0);
    chk({tag, "_rx"}, bus_b.right_word_idx, 0);
    chk({tag, "_res_y"}, bus_b.result_y_out, 0);
    chk({tag, "_res_x"}, bus_b.result_x_out, 0);
    chk({tag, "_res_d"}, bus_b.result_disp_out, 0);
    chk({tag, "_res_c"}, bus_b.result_cost_out, 0);
  endtask
  task automatic chk_fetch(input string tag, input int i);
    chk({tag, "_ly"}, bus_b.left_current_y, fq[i].y);
    chk({tag, "_ry"}, bus_b.right_current_y, fq[i].y);
    chk({tag, "_lx"}, bus_b.left_word_idx, fq[i].x);
    chk({tag, "_rx"}, bus_b.right_word_idx, fq[i].x - fq[i].d);
  endtask
  initial begin
    int fi, ri, cur, fc, cc, cyc, x2cnt, last_y, last_x, pulses;
    bit done_seen;
    bus_a.start_in = 0; bus_a.fetch_done_in = 0; bus_a.cost_valid_in = 0; bus_a.cost_in = 0;
    bus_b.start_in = 0; bus_b.fetch_done_in = 0; bus_b.cost_valid_in = 0; bus_b.cost_in = 0;
    tick();
    tick();
    chk_idle_b("reset");
    chk("reset_a_busy", bus_a.busy_out, 0);
    rst = 1'b0;
    tick();
    frame_a(50, 30, 30);
    frame_a(50, 40, 30);
    for (int y = 0; y + 6 <= 320; y += 6)
      for (int x = 0; x <= 38; x++) begin
        int bc = 16'hFFFF;
        int bd = 0;
        for (int d = 0; d < 4 && d <= x; d++) begin
          int c = ($urandom_range(0, 15) == 0) ? 16'hFFFF : int'($urandom_range(0, 7));
          fq.push_back('{y, x, d, c});
          if (c < bc) begin bc = c; bd = d; end
        end
        rq.push_back('{y, x, bd, bc});
      end
    fi = 0; ri = 0; cur = 0; fc = 0; cc = 0; cyc = 0; x2cnt = 0; last_y = -1; last_x = -1;
    done_seen = 0;
    bus_b.start_in = 1'b1;
    tick();
    chk("frame_busy", bus_b.busy_out, 1);
    while (!done_seen && cyc < 80000) begin
      bus_b.fetch_done_in = 1'b0;
      bus_b.cost_valid_in = 1'b0;
      bus_b.start_in = $urandom_range(0, 7) == 0;
      if (bus_b.done_out) begin
        done_seen = 1;
        bus_b.start_in = 1'b0;
        chk("done_busy", bus_b.busy_out, 0);
      end else chk("frame_busy_hold", bus_b.busy_out, 1);
      if (bus_b.fetch_valid_out) begin
        chk("fetch_extra", 32'(fi < fq.size()), 1);
        if (fi < fq.size()) begin
          chk_fetch("fetch", fi);
          if (fq[fi].y == 0 && fq[fi].x == 2) x2cnt++;
          cur = fi;
          fi++;
        end
        fc = (fi == 6) ? 21 : int'($urandom_range(1, 2));
      end else if (fc > 0) begin
        chk("stall_compute", bus_b.compute_valid_out, 0);
        chk_fetch("stall", cur);
        fc--;
        if (fc == 0) bus_b.fetch_done_in = 1'b1;
        else if ($urandom_range(0, 3) == 0) begin
          bus_b.cost_valid_in = 1'b1;
          bus_b.cost_in = 16'h0;
        end
      end
      if (bus_b.compute_valid_out) cc = $urandom_range(1, 2);
      else if (cc > 0) begin
        cc--;
        if (cc == 0) begin
          bus_b.cost_valid_in = 1'b1;
          bus_b.cost_in = 16'(fq[cur].c);
        end
      end
      if (bus_b.result_valid_out) begin
        chk("result_extra", 32'(ri < rq.size()), 1);
        if (ri < rq.size()) begin
          chk("res_y", bus_b.result_y_out, rq[ri].y);
          chk("res_x", bus_b.result_x_out, rq[ri].x);
          chk("res_disp", bus_b.result_disp_out, rq[ri].d);
          chk("res_cost", bus_b.result_cost_out, rq[ri].c);
        end
        last_y = bus_b.result_y_out;
        last_x = bus_b.result_x_out;
        ri++;
      end
      tick();
      cyc++;
    end
    bus_b.start_in = 1'b0;
    bus_b.fetch_done_in = 1'b0;
    bus_b.cost_valid_in = 1'b0;
    chk("frame_done_seen", 32'(done_seen), 1);
    chk("result_count", ri, 2067);
    chk("fetch_count", fi, fq.size());
    chk("last_y", last_y, 312);
    chk("last_x", last_x, 38);
    chk("clamp_x2_fetches", x2cnt, 3);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      pulses += int'(bus_b.done_out) + int'(bus_b.fetch_valid_out) + int'(bus_b.busy_out);
      tick();
    end
    chk("post_frame_quiet", pulses, 0);
    bus_b.start_in = 1'b1;
    tick();
    bus_b.start_in = 1'b0;
    chk("mid_fetch", bus_b.fetch_valid_out, 1);
    tick();
    bus_b.fetch_done_in = 1'b1;
    tick();
    bus_b.fetch_done_in = 1'b0;
    chk("mid_compute", bus_b.compute_valid_out, 1);
    tick();
    rst = 1'b1;
    tick();
    chk_idle_b("mid_rst");
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      bus_b.cost_valid_in = 1'b1;
      bus_b.fetch_done_in = i[0];
      tick();
      pulses += int'(bus_b.result_valid_out) + int'(bus_b.done_out) + int'(bus_b.fetch_valid_out);
    end
    bus_b.cost_valid_in = 1'b0;
    bus_b.fetch_done_in = 1'b0;
    chk("abort_quiet", pulses, 0);
    bus_b.start_in = 1'b1;
    tick();
    bus_b.start_in = 1'b0;
    chk("restart_fv", bus_b.fetch_valid_out, 1);
    chk("restart_y", bus_b.left_current_y, 0);
    chk("restart_x", bus_b.left_word_idx, 0);
    chk("restart_busy", bus_b.busy_out, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
